// File: rtl/mem_common_pkg.sv
// Shared definitions for the memory read path: FSM state encoding and response FIFO entry width.
package mem_common_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StFlush = 2'd2
   } mem_state_e;

   // A FIFO entry carries the data word plus its last-of-burst flag in the MSB.
   function automatic int unsigned fifo_entry_w(input int unsigned data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/mem_rd_resp_fifo.sv
// Synchronous response FIFO with occupancy count and synchronous clear; Depth must be a power of 2.
module mem_rd_resp_fifo #(
   parameter int unsigned Width = 9,
   parameter int unsigned Depth = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [Width-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [Width-1:0]         pop_data_o,
   output logic                     empty_o,
   output logic [$clog2(Depth):0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW:0]    wr_ptr_q;
   logic [PtrW:0]    rd_ptr_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
   end

   assign pop_data_o = mem_q[rd_ptr_q[PtrW-1:0]];
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign count_o    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/mem_rd_streamer.sv
// Burst read sequencer: issues credit-limited reads to a 1-cycle-latency memory and streams the words.
// Optional abort/flush support is enabled by defining MEM_RD_STREAMER_ABORT_EN.
module mem_rd_streamer
   import mem_common_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned LEN_W      = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic              cmd_vld_i,
   output logic              cmd_rdy_o,
`ifdef MEM_RD_STREAMER_ABORT_EN
   input  logic              abort_i,
`endif
   output logic [ADDR_W-1:0] mem_rd_addr_o,
   output logic              mem_rd_vld_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   input  logic              mem_rd_rdy_i,
   output logic [DATA_W-1:0] strm_data_o,
   output logic              strm_last_o,
   output logic              strm_vld_o,
   input  logic              strm_rdy_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ENTRY_W = fifo_entry_w(DATA_W);

   mem_state_e        state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issue_left_q;
   logic [LEN_W-1:0]  push_cnt_q;
   logic              issue_pending_q;
   logic              inflight_q;

   logic               issue;
   logic               push;
   logic               pop;
   logic               fifo_clr;
   logic               fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W:0]     credit_used;
   logic [ENTRY_W-1:0] fifo_rd_data;

`ifdef MEM_RD_STREAMER_ABORT_EN
   logic abort;
   assign abort    = abort_i & (state_q == StRun);
   assign fifo_clr = abort | (state_q == StFlush);
`else
   assign fifo_clr = 1'b0;
`endif

   // Memory cannot be stalled, so every read needs a guaranteed FIFO slot before it is issued.
   assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
   assign issue       = (state_q == StRun) & issue_pending_q
                        & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
   assign push        = mem_rd_rdy_i & inflight_q & (state_q == StRun);
   assign pop         = strm_vld_o & strm_rdy_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         addr_q          <= '0;
         len_q           <= '0;
         issue_left_q    <= '0;
         push_cnt_q      <= '0;
         issue_pending_q <= 1'b0;
         inflight_q      <= 1'b0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            addr_q       <= addr_q + ADDR_W'(1);
            issue_left_q <= issue_left_q - LEN_W'(1);
            if (issue_left_q == '0) issue_pending_q <= 1'b0;
         end
         if (push) push_cnt_q <= push_cnt_q + LEN_W'(1);
         unique case (state_q)
            StIdle: begin
               if (cmd_vld_i) begin
                  state_q         <= StRun;
                  addr_q          <= cmd_addr_i;
                  len_q           <= cmd_len_i;
                  issue_left_q    <= cmd_len_i;
                  push_cnt_q      <= '0;
                  issue_pending_q <= 1'b1;
               end
            end
            StRun: begin
`ifdef MEM_RD_STREAMER_ABORT_EN
               if (abort) begin
                  state_q         <= StFlush;
                  issue_pending_q <= 1'b0;
               end else
`endif
               if (pop && fifo_rd_data[DATA_W]) state_q <= StIdle;
            end
`ifdef MEM_RD_STREAMER_ABORT_EN
            // Any read issued in the abort cycle returns here and is discarded.
            StFlush: begin
               if (!inflight_q) state_q <= StIdle;
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

   mem_rd_resp_fifo #(
      .Width (ENTRY_W),
      .Depth (FIFO_DEPTH)
   ) u_resp_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (fifo_clr),
      .push_i      (push),
      .push_data_i ({(push_cnt_q == len_q), mem_rd_data_i}),
      .pop_i       (pop),
      .pop_data_o  (fifo_rd_data),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign cmd_rdy_o     = (state_q == StIdle);
   assign busy_o        = (state_q != StIdle);
   assign mem_rd_vld_o  = issue;
   assign mem_rd_addr_o = addr_q;
   assign strm_vld_o    = ~fifo_empty & (state_q == StRun);
   assign strm_data_o   = strm_vld_o ? fifo_rd_data[DATA_W-1:0] : '0;
   assign strm_last_o   = strm_vld_o & fifo_rd_data[DATA_W];

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Scoreboard bench for mem_rd_streamer; abort scenario runs when MEM_RD_STREAMER_ABORT_EN is defined.
module tb_mem_rd_streamer;

   localparam int DATA_W     = 8;
   localparam int ADDR_W     = 8;
   localparam int LEN_W      = 8;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] cmd_addr_i;
   logic [LEN_W-1:0]  cmd_len_i;
   logic              cmd_vld_i;
   logic              cmd_rdy_o;
   logic [ADDR_W-1:0] mem_rd_addr_o;
   logic              mem_rd_vld_o;
   logic [DATA_W-1:0] mem_rd_data_i;
   logic              mem_rd_rdy_i;
   logic [DATA_W-1:0] strm_data_o;
   logic              strm_last_o;
   logic              strm_vld_o;
   logic              strm_rdy_i;
   logic              busy_o;
`ifdef MEM_RD_STREAMER_ABORT_EN
   logic              abort_i;
`endif

   logic       stale_inj;
   logic       mon_en;
   logic       skip_sb;
   logic       prev_stall;
   logic [8:0] prev_beat;
   logic [7:0] exp_addr[$];
   logic [8:0] exp_beat[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         rd_total = 0;
   int         pop_total = 0;

   always #5 clk = ~clk;

   mem_rd_streamer #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_addr_i    (cmd_addr_i),
      .cmd_len_i     (cmd_len_i),
      .cmd_vld_i     (cmd_vld_i),
      .cmd_rdy_o     (cmd_rdy_o),
`ifdef MEM_RD_STREAMER_ABORT_EN
      .abort_i       (abort_i),
`endif
      .mem_rd_addr_o (mem_rd_addr_o),
      .mem_rd_vld_o  (mem_rd_vld_o),
      .mem_rd_data_i (mem_rd_data_i),
      .mem_rd_rdy_i  (mem_rd_rdy_i),
      .strm_data_o   (strm_data_o),
      .strm_last_o   (strm_last_o),
      .strm_vld_o    (strm_vld_o),
      .strm_rdy_i    (strm_rdy_i),
      .busy_o        (busy_o)
   );

   function automatic logic [7:0] memval(input logic [7:0] a);
      return (a ^ 8'h5A) + 8'h03;
   endfunction

   // Memory model: 1-cycle read latency, no backpressure.
   always @(posedge clk) begin
      mem_rd_rdy_i  <= mem_rd_vld_o | stale_inj;
      mem_rd_data_i <= memval(mem_rd_addr_o);
   end

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: compares issued reads and stream beats against the expectation queues.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (prev_stall) begin
            check("stall_hold_vld", int'(strm_vld_o), 1);
            check("stall_hold_beat", int'({strm_last_o, strm_data_o}), int'(prev_beat));
         end
         if (mem_rd_vld_o) begin
            rd_total++;
            check("credit_limit", int'((rd_total - pop_total) <= FIFO_DEPTH), 1);
            if (!skip_sb) begin
               if (exp_addr.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL rd_unexpected: got addr 0x%0h, required no read", mem_rd_addr_o);
               end else begin
                  check("rd_addr", int'(mem_rd_addr_o), int'(exp_addr.pop_front()));
               end
            end
         end
         if (strm_vld_o && strm_rdy_i) begin
            pop_total++;
            if (!skip_sb) begin
               if (exp_beat.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL beat_unexpected: got beat 0x%0h, required no beat",
                           {strm_last_o, strm_data_o});
               end else begin
                  check("beat", int'({strm_last_o, strm_data_o}), int'(exp_beat.pop_front()));
               end
            end
         end
         prev_stall = strm_vld_o && !strm_rdy_i;
         prev_beat  = {strm_last_o, strm_data_o};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_burst(input logic [7:0] a, input logic [7:0] l);
      logic [7:0] ad;
      for (int i = 0; i <= int'(l); i++) begin
         ad = a + 8'(i);
         exp_addr.push_back(ad);
         exp_beat.push_back({(i == int'(l)), memval(ad)});
      end
   endtask

   // Called #1 after a posedge; returns #1 after the handshake edge (cycle 1 of the burst).
   task automatic send_cmd(input logic [7:0] a, input logic [7:0] l);
      int t = 0;
      while (!cmd_rdy_o && t < 300) begin
         tick();
         t++;
      end
      check("cmd_rdy_wait", int'(t < 300), 1);
      cmd_addr_i = a;
      cmd_len_i  = l;
      cmd_vld_i  = 1'b1;
      tick();
      cmd_vld_i  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while ((exp_beat.size() != 0 || !cmd_rdy_o) && t < 300) begin
         tick();
         t++;
      end
      check({name, "_done"}, int'(t < 300), 1);
      check({name, "_rd_left"}, exp_addr.size(), 0);
   endtask

   task automatic check_reset(input string name);
      check({name, "_cmd_rdy"}, int'(cmd_rdy_o), 1);
      check({name, "_rd_vld"}, int'(mem_rd_vld_o), 0);
      check({name, "_rd_addr"}, int'(mem_rd_addr_o), 0);
      check({name, "_strm_vld"}, int'(strm_vld_o), 0);
      check({name, "_strm_last"}, int'(strm_last_o), 0);
      check({name, "_strm_data"}, int'(strm_data_o), 0);
      check({name, "_busy"}, int'(busy_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      int r0;
      int t;
      rst_n      = 1'b0;
      cmd_addr_i = '0;
      cmd_len_i  = '0;
      cmd_vld_i  = 1'b0;
      strm_rdy_i = 1'b0;
      stale_inj  = 1'b0;
      mon_en     = 1'b0;
      skip_sb    = 1'b0;
      prev_stall = 1'b0;
      prev_beat  = '0;
`ifdef MEM_RD_STREAMER_ABORT_EN
      abort_i    = 1'b0;
`endif
      repeat (3) tick();
      check_reset("init");
      rst_n  = 1'b1;
      mon_en = 1'b1;
      tick();

      // Single word with latency profile.
      strm_rdy_i = 1'b1;
      expect_burst(8'h10, 8'd0);
      send_cmd(8'h10, 8'd0);
      @(negedge clk);
      check("lat_c1_rd_vld", int'(mem_rd_vld_o), 1);
      check("lat_c1_rd_addr", int'(mem_rd_addr_o), 'h10);
      check("lat_c1_busy", int'(busy_o), 1);
      @(negedge clk);
      check("lat_c2_strm_vld", int'(strm_vld_o), 0);
      @(negedge clk);
      check("lat_c3_strm_vld", int'(strm_vld_o), 1);
      check("lat_c3_strm_last", int'(strm_last_o), 1);
      check("lat_c3_strm_data", int'(strm_data_o), 'h4D);
      wait_done("single");

      // Full rate: 8 consecutive reads and 8 beats in 8 cycles.
      p0 = pop_total;
      expect_burst(8'h00, 8'd7);
      send_cmd(8'h00, 8'd7);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("full_rate_rd_vld", int'(mem_rd_vld_o), 1);
      end
      tick();
      tick();
      tick();
      check("full_rate_beats", pop_total - p0, 8);
      check("full_rate_cmd_rdy", int'(cmd_rdy_o), 1);
      wait_done("full_rate");

      // Backpressure: only FIFO_DEPTH reads may issue while the stream is stalled.
      strm_rdy_i = 1'b0;
      r0 = rd_total;
      p0 = pop_total;
      expect_burst(8'h40, 8'd15);
      send_cmd(8'h40, 8'd15);
      repeat (20) tick();
      check("bp_reads_issued", rd_total - r0, FIFO_DEPTH);
      check("bp_no_beats", pop_total - p0, 0);
      for (int i = 0; i < 30; i++) begin
         strm_rdy_i = (i % 3 != 0);
         tick();
      end
      strm_rdy_i = 1'b1;
      wait_done("backpressure");

      // Address wrap.
      expect_burst(8'hFE, 8'd3);
      send_cmd(8'hFE, 8'd3);
      wait_done("wrap");

      // Reset mid-burst, then a stale memory response that must be ignored.
      mon_en = 1'b0;
      send_cmd(8'h80, 8'd7);
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check_reset("midrst");
      rst_n     = 1'b1;
      stale_inj = 1'b1;
      tick();
      stale_inj = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stale_strm_vld", int'(strm_vld_o), 0);
         check("stale_busy", int'(busy_o), 0);
      end
      exp_addr.delete();
      exp_beat.delete();
      rd_total  = 0;
      pop_total = 0;
      mon_en    = 1'b1;
      expect_burst(8'h20, 8'd2);
      send_cmd(8'h20, 8'd2);
      wait_done("post_reset");

`ifdef MEM_RD_STREAMER_ABORT_EN
      // Abort after 3 beats of a 10-word burst.
      p0 = pop_total;
      expect_burst(8'h60, 8'd9);
      send_cmd(8'h60, 8'd9);
      t = 0;
      while ((pop_total - p0) < 3 && t < 50) begin
         tick();
         t++;
      end
      check("abort_3_beats", int'(t < 50), 1);
      abort_i = 1'b1;
      skip_sb = 1'b1;
      tick();
      abort_i = 1'b0;
      check("flush_strm_vld", int'(strm_vld_o), 0);
      check("flush_rd_vld", int'(mem_rd_vld_o), 0);
      t = 0;
      while (!cmd_rdy_o && t < 2) begin
         tick();
         check("flush_strm_vld_hold", int'(strm_vld_o), 0);
         t++;
      end
      check("abort_idle_cmd_rdy", int'(cmd_rdy_o), 1);
      check("abort_idle_busy", int'(busy_o), 0);
      exp_addr.delete();
      exp_beat.delete();
      pop_total = rd_total;
      skip_sb   = 1'b0;
      expect_burst(8'h70, 8'd1);
      send_cmd(8'h70, 8'd1);
      wait_done("post_abort");
`endif

      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
